sevseg_display_arbiter: RTL and testbench
=========================================

Name: sevseg_display_arbiter

Overview:
- Shares the board's 8-digit seven-segment bank between NREQ independent clients (e.g. counter, PS/2 keyboard decoder, debug monitor).
- Each client requests the display with a 32-bit packed nibble value and a per-digit blank mask.
- A round-robin scheduler grants ownership and enforces a minimum on-screen hold time.
- Output feeds the existing per-digit sevseg decoders directly. numbers[4*i+3:4*i] drives digit i.

Parameters:
- NREQ, 4, number of requesting clients (2..8).
- HOLD_CYCLES, 50_000_000, minimum cycles a newly granted owner keeps the display before another client may take it (>=1; 1 s at CLOCK_50).
- CNT_W, 26, width of hold counter; must satisfy 2**CNT_W > HOLD_CYCLES-1.

Ports:
- clk, input, 1, system clock (CLOCK_50 domain).
- rst_n, input, 1, asynchronous active-low reset.
- req, input, NREQ, per-client request level; held until gnt or withdrawn.
- value, input, 32*NREQ, client k value in bits [32k+31:32k]; nibble i shows on digit i.
- blank, input, 8*NREQ, client k blank mask in [8k+7:8k]; 1 = digit off.
- gnt, output, NREQ, one-hot, one-cycle acknowledge of accepted request.
- owner, output, 3, index of current display owner.
- numbers, output, 32, latched nibble value for sevseg decoders.
- digit_en, output, 8, latched ~blank of owner; 0 = digit blanked.
- busy, output, 1, high while in HOLD with count != 0 (display locked).

Behaviour:
- Reset (async, rst_n=0): state=IDLE, gnt=0, owner=0, numbers=0, digit_en=0, busy=0, cnt=0, rr pointer last=NREQ-1 (so search starts at client 0). Release is synchronous to clk.
- States:
  - IDLE: nothing displayed.
  - HOLD: owner locked; cnt counting down.
  - FREE: owner still displayed, lock expired.
- Arbitration (IDLE, FREE, HOLD with cnt==0): round-robin search over req starting at last+1 mod NREQ. Winner w at clock edge k yields, registered at edge k:
  - gnt[w]=1 for exactly that cycle; owner=w; last=w.
  - numbers=value[w]; digit_en=~blank[w].
  - cnt=HOLD_CYCLES-1; state=HOLD.
  - Latency req sampled -> gnt/numbers visible: 1 cycle.
- HOLD, cnt!=0:
  - cnt decrements each cycle; busy=1.
  - Requests from non-owners are ignored and stay pending; no gnt.
  - req[owner]=1: refresh numbers/digit_en from owner inputs, pulse gnt[owner]. cnt is not reloaded and keeps decrementing.
- HOLD, cnt==0: busy=0; full arbitration runs in this cycle.
  - Owner competes as lowest priority, because last=owner.
  - If no req is asserted, go to FREE with display unchanged.
  - Earliest takeover after a grant at edge g occurs at edge g+HOLD_CYCLES.
- FREE: any req is granted immediately via round-robin. Display contents persist indefinitely without requests.
- gnt is never asserted in two consecutive cycles to different clients during HOLD with cnt!=0. At most one gnt bit is high in any cycle.
- A request dropped before its grant is forgotten; there is no internal queue.
- req bits with index >= NREQ do not exist. Owner index width is 3 regardless of NREQ; upper bits are 0.
- Simultaneous owner refresh and counter expiry: arbitration rule applies, and the owner wins only if no other client requests.
- Reset mid-HOLD: immediate return to reset values; the next arbitration starts at client 0.

Test Plan:
All scenarios use NREQ=4, HOLD_CYCLES=4.
- Reset: assert rst_n=0 mid-cycle with req=4'b1111 -> gnt=0, numbers=0, digit_en=0, busy=0, owner=0 asynchronously.
- Single grant: from IDLE, req=4'b0100, value[2]=32'h1234_5678, blank[2]=8'hF0 -> next edge gnt=4'b0100, owner=2, numbers=32'h12345678, digit_en=8'h0F, busy=1.
- Round-robin fairness: from IDLE, req=4'b1011 held (each client drops its bit on gnt) -> grants 0,1,3 at edges g, g+4, g+8. gnt is 0 in all other cycles.
- Owner refresh: owner 0 granted at g; at g+2, req[0]=1 with value 32'hDEAD_BEEF while req[1]=1 -> gnt[0] at g+2, numbers=32'hDEADBEEF; gnt[1] not before g+4.
- Withdrawn request: owner 2 granted at g; req[1] high during g+1..g+2 only -> no gnt[1]; state FREE at g+4 with numbers unchanged; later req[3] granted 1 cycle after assertion.
- Reset mid-HOLD: pulse rst_n low at g+2 -> outputs cleared; with req=4'b1100 after release, first grant goes to client 2.

Source files
------------

// File: rtl/sevseg_display_arbiter.sv
// Round-robin arbiter sharing an 8-digit seven-segment bank between NREQ clients.
// A newly granted owner keeps the display for at least HOLD_CYCLES cycles.
// During that time the owner may refresh its contents, and other clients wait.
// Ports:
//   clk, rst_n       - clock, asynchronous active-low reset
//   req   [NREQ]     - per-client request level
//   value [32*NREQ]  - client k nibble value in [32k+31:32k]
//   blank [8*NREQ]   - client k blank mask in [8k+7:8k], 1 = digit off
//   gnt   [NREQ]     - one-cycle, one-hot acknowledge of an accepted request
//   owner [3]        - index of the current display owner
//   numbers [32]     - latched nibble value, nibble i drives digit i
//   digit_en [8]     - latched ~blank of the owner, 0 = digit blanked
//   busy             - display locked (HOLD with count != 0)
module sevseg_display_arbiter #(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned HOLD_CYCLES = 50_000_000,
  parameter int unsigned CNT_W       = 26
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [32*NREQ-1:0]   value,
  input  logic [8*NREQ-1:0]    blank,
  output logic [NREQ-1:0]      gnt,
  output logic [2:0]           owner,
  output logic [31:0]          numbers,
  output logic [7:0]           digit_en,
  output logic                 busy
);

  localparam int unsigned OW   = 3;
  localparam int unsigned NMAX = 8;

  typedef enum logic [1:0] {IDLE, HOLD, FREE} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [OW-1:0]    last, last_nx;
  logic [OW-1:0]    owner_nx;
  logic [NREQ-1:0]  gnt_nx;
  logic [31:0]      numbers_nx;
  logic [7:0]       digit_en_nx;
  logic             busy_nx;

  // Client inputs padded to 8 entries so a 3-bit index always selects exactly.
  logic [NMAX-1:0]  req8;
  logic [31:0]      val8 [NMAX];
  logic [7:0]       den8 [NMAX];

  for (genvar k = 0; k < NMAX; k++) begin : g_pad
    if (k < NREQ) begin : g_live
      assign req8[k] = req[k];
      assign val8[k] = value[32*k +: 32];
      assign den8[k] = ~blank[8*k +: 8];
    end else begin : g_tie
      assign req8[k] = 1'b0;
      assign val8[k] = 32'h0;
      assign den8[k] = 8'h0;
    end
  end

  // Round-robin pick: first requester above last, else first requester overall.
  logic          win_hi, win_lo, win_valid;
  logic [OW-1:0] idx_hi, idx_lo, win_idx;

  always_comb begin
    win_hi = 1'b0;
    win_lo = 1'b0;
    idx_hi = '0;
    idx_lo = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (req8[j] && !win_hi && (j > 32'(last))) begin
        win_hi = 1'b1;
        idx_hi = OW'(j);
      end
      if (req8[j] && !win_lo) begin
        win_lo = 1'b1;
        idx_lo = OW'(j);
      end
    end
    win_valid = win_hi | win_lo;
    win_idx   = win_hi ? idx_hi : idx_lo;
  end

  // Next-state and registered-output values.
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    last_nx     = last;
    owner_nx    = owner;
    numbers_nx  = numbers;
    digit_en_nx = digit_en;
    gnt_nx      = '0;
    busy_nx     = 1'b0;

    case (state)
      HOLD: begin
        if (cnt != '0) begin
          cnt_nx = cnt - CNT_W'(1);
          // Owner refresh: contents update, lock timer keeps running.
          if (req8[owner]) begin
            numbers_nx  = val8[owner];
            digit_en_nx = den8[owner];
            gnt_nx      = NREQ'(8'd1 << owner);
          end
        end else if (win_valid) begin
          state_nx    = HOLD;
          cnt_nx      = CNT_W'(HOLD_CYCLES - 1);
          last_nx     = win_idx;
          owner_nx    = win_idx;
          numbers_nx  = val8[win_idx];
          digit_en_nx = den8[win_idx];
          gnt_nx      = NREQ'(8'd1 << win_idx);
        end else begin
          state_nx = FREE;
        end
      end
      default: begin
        if (win_valid) begin
          state_nx    = HOLD;
          cnt_nx      = CNT_W'(HOLD_CYCLES - 1);
          last_nx     = win_idx;
          owner_nx    = win_idx;
          numbers_nx  = val8[win_idx];
          digit_en_nx = den8[win_idx];
          gnt_nx      = NREQ'(8'd1 << win_idx);
        end
      end
    endcase

    busy_nx = (state_nx == HOLD) && (cnt_nx != '0);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      last     <= OW'(NREQ - 1);
      owner    <= '0;
      gnt      <= '0;
      numbers  <= '0;
      digit_en <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      last     <= last_nx;
      owner    <= owner_nx;
      gnt      <= gnt_nx;
      numbers  <= numbers_nx;
      digit_en <= digit_en_nx;
      busy     <= busy_nx;
    end
  end

endmodule

// File: tb/tb_sevseg_display_arbiter.sv
// Directed bench for sevseg_display_arbiter with NREQ=4, HOLD_CYCLES=4.
module tb_sevseg_display_arbiter;

  localparam int unsigned NREQ = 4;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [32*NREQ-1:0] value;
  logic [8*NREQ-1:0] blank;
  logic [NREQ-1:0]   gnt;
  logic [2:0]        owner;
  logic [31:0]       numbers;
  logic [7:0]        digit_en;
  logic              busy;

  int n_checks;
  int n_fail;

  sevseg_display_arbiter #(
    .NREQ(NREQ), .HOLD_CYCLES(4), .CNT_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .value(value), .blank(blank),
    .gnt(gnt), .owner(owner), .numbers(numbers), .digit_en(digit_en), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Client values v0..v3 and blank masks b0..b3.
  localparam logic [127:0] VAL_DEF = {32'h8765_4321, 32'h1234_5678, 32'h2222_1111, 32'h1111_0000};
  localparam logic [31:0]  BLK_DEF = {8'h5A, 8'hF0, 8'hFF, 8'h00};

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  exp_gnt;
    logic [2:0]  exp_owner;
    logic [31:0] exp_numbers;
    logic [7:0]  exp_den;
    logic        exp_busy;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    req   = '0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    req      = '0;
    value    = VAL_DEF;
    blank    = BLK_DEF;

    vecs[0] = '{4'b0100, 4'b0100, 3'd2, 32'h1234_5678, 8'h0F, 1'b1};
    vecs[1] = '{4'b1010, 4'b0010, 3'd1, 32'h2222_1111, 8'h00, 1'b1};
    vecs[2] = '{4'b1000, 4'b1000, 3'd3, 32'h8765_4321, 8'hA5, 1'b1};
    vecs[3] = '{4'b1111, 4'b0001, 3'd0, 32'h1111_0000, 8'hFF, 1'b1};
    vecs[4] = '{4'b0000, 4'b0000, 3'd0, 32'h0000_0000, 8'h00, 1'b0};

    repeat (2) @(posedge clk);

    // Asynchronous reset mid-cycle while a client holds the display.
    reset_dut();
    req = 4'b1111;
    tick();
    check("pre_reset_gnt", 64'(gnt), 64'(4'b0001));
    #2 rst_n = 1'b0;
    #1;
    check("arst_gnt", 64'(gnt), 64'h0);
    check("arst_owner", 64'(owner), 64'h0);
    check("arst_numbers", 64'(numbers), 64'h0);
    check("arst_den", 64'(digit_en), 64'h0);
    check("arst_busy", 64'(busy), 64'h0);

    // Single grants from IDLE.
    for (int i = 0; i < 5; i++) begin
      reset_dut();
      req = vecs[i].req;
      tick();
      check($sformatf("vec%0d_gnt", i), 64'(gnt), 64'(vecs[i].exp_gnt));
      check($sformatf("vec%0d_owner", i), 64'(owner), 64'(vecs[i].exp_owner));
      check($sformatf("vec%0d_numbers", i), 64'(numbers), 64'(vecs[i].exp_numbers));
      check($sformatf("vec%0d_den", i), 64'(digit_en), 64'(vecs[i].exp_den));
      check($sformatf("vec%0d_busy", i), 64'(busy), 64'(vecs[i].exp_busy));
    end

    // Round-robin: grants 0,1,3 at g, g+4, g+8; each client drops on grant.
    reset_dut();
    req = 4'b1011;
    for (int c = 0; c <= 8; c++) begin
      logic [3:0] eg;
      tick();
      eg = (c == 0) ? 4'b0001 : (c == 4) ? 4'b0010 : (c == 8) ? 4'b1000 : 4'b0000;
      check($sformatf("rr_gnt_c%0d", c), 64'(gnt), 64'(eg));
      if (c == 2) check("rr_busy_c2", 64'(busy), 64'h1);
      if (c == 3) check("rr_busy_c3", 64'(busy), 64'h0);
      req = req & ~gnt;
    end
    check("rr_owner_end", 64'(owner), 64'd3);

    // Owner refresh during HOLD; client 1 waits until g+4.
    reset_dut();
    req = 4'b0001;
    tick();
    check("ref_gnt_g", 64'(gnt), 64'(4'b0001));
    req = 4'b0010;
    tick();
    check("ref_gnt_g1", 64'(gnt), 64'h0);
    req = 4'b0011;
    value[31:0] = 32'hDEAD_BEEF;
    tick();
    check("ref_gnt_g2", 64'(gnt), 64'(4'b0001));
    check("ref_numbers_g2", 64'(numbers), 64'hDEAD_BEEF);
    check("ref_busy_g2", 64'(busy), 64'h1);
    req = 4'b0010;
    tick();
    check("ref_gnt_g3", 64'(gnt), 64'h0);
    tick();
    check("ref_gnt_g4", 64'(gnt), 64'(4'b0010));
    check("ref_owner_g4", 64'(owner), 64'd1);
    check("ref_numbers_g4", 64'(numbers), 64'h2222_1111);
    value = VAL_DEF;

    // Withdrawn request is forgotten; display persists in FREE.
    reset_dut();
    req = 4'b0100;
    tick();
    check("wd_gnt_g", 64'(gnt), 64'(4'b0100));
    req = 4'b0010;
    tick();
    check("wd_gnt_g1", 64'(gnt), 64'h0);
    tick();
    check("wd_gnt_g2", 64'(gnt), 64'h0);
    req = 4'b0000;
    repeat (4) begin
      tick();
      check("wd_gnt_idle", 64'(gnt), 64'h0);
    end
    check("wd_busy_free", 64'(busy), 64'h0);
    check("wd_owner_free", 64'(owner), 64'd2);
    check("wd_numbers_free", 64'(numbers), 64'h1234_5678);
    check("wd_den_free", 64'(digit_en), 64'h0F);
    req = 4'b1000;
    tick();
    check("wd_gnt_late", 64'(gnt), 64'(4'b1000));
    check("wd_owner_late", 64'(owner), 64'd3);
    check("wd_numbers_late", 64'(numbers), 64'h8765_4321);

    // Reset mid-HOLD clears outputs and restarts round-robin at client 0.
    reset_dut();
    req = 4'b0100;
    tick();
    check("rh_gnt_g", 64'(gnt), 64'(4'b0100));
    req = 4'b0000;
    tick();
    tick();
    check("rh_busy_g2", 64'(busy), 64'h1);
    rst_n = 1'b0;
    #1;
    check("rh_owner", 64'(owner), 64'h0);
    check("rh_numbers", 64'(numbers), 64'h0);
    check("rh_den", 64'(digit_en), 64'h0);
    check("rh_busy", 64'(busy), 64'h0);
    req = 4'b1100;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rh_gnt_after", 64'(gnt), 64'(4'b0100));
    check("rh_owner_after", 64'(owner), 64'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
